mul_div_unit: RTL and testbench

- Multi-cycle signed multiply/divide engine.
- Sits directly upstream of the 64-bit Z/HI-LO holding register on the datapath bus.
- Takes two WIDTH-bit operands and produces a 2*WIDTH-bit result plus a one-cycle done strobe.
- The control unit uses done as the load enable for the downstream register.
- Multiply: radix-2 Booth. Divide: non-restoring, with a final correction step.

---
 rtl/mul_div_pkg.sv | 17 +
 rtl/mul_div_unit_if.sv | 24 ++
 rtl/mul_div_step.sv | 45 ++++
 rtl/mul_div_unit.sv | 142 ++++++++++++++
 tb/tb_mul_div_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_pkg.sv
// Shared encodings for the multi-cycle signed multiply/divide engine:
// operation codes, FSM state codes and the iteration-counter width helper.
package mul_div_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the control unit (master) and the
// multiply/divide engine (slave).
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic                      start;
    logic                      op;
    logic signed [WIDTH-1:0]   opa;
    logic signed [WIDTH-1:0]   opb;
    logic        [2*WIDTH-1:0] result;
    logic                      busy;
    logic                      done;
    logic                      div_zero;

    modport master (
        output start, op, opa, opb,
        input  result, busy, done, div_zero
    );

    modport slave (
        input  start, op, opa, opb,
        output result, busy, done, div_zero
    );
endinterface

// File: rtl/mul_div_step.sv
// One combinational iteration: radix-2 Booth add/sub + arithmetic shift right,
// or non-restoring add/sub + shift left of the {remainder, quotient} pair.
module mul_div_step
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  op,
    input  logic signed [WIDTH:0] acc,
    input  logic [WIDTH-1:0]      q,
    input  logic                  qm1,
    input  logic signed [WIDTH:0] m,
    output logic signed [WIDTH:0] acc_nx,
    output logic [WIDTH-1:0]      q_nx,
    output logic                  qm1_nx
);

    logic signed [WIDTH:0] sum;
    logic signed [WIDTH:0] shifted;

    always_comb begin
        sum     = acc;
        shifted = acc;
        acc_nx  = acc;
        q_nx    = q;
        qm1_nx  = qm1;
        if (op == OP_MUL) begin
            case ({q[0], qm1})
                2'b01:   sum = acc + m;
                2'b10:   sum = acc - m;
                default: sum = acc;
            endcase
            acc_nx = {sum[WIDTH], sum[WIDTH:1]};
            q_nx   = {sum[0], q[WIDTH-1:1]};
            qm1_nx = q[0];
        end else begin
            // Sign of the partial remainder picks subtract (>= 0) or add-back (< 0).
            shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
            sum     = acc[WIDTH] ? (shifted + m) : (shifted - m);
            acc_nx  = sum;
            q_nx    = {q[WIDTH-2:0], ~sum[WIDTH]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (Booth) / divide (non-restoring on magnitudes)
// engine feeding the HI/LO holding register; done doubles as its load enable.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          clear_n,
    mul_div_unit_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic                  op_q;
    logic                  div_zero_q;
    logic [2*WIDTH-1:0]    result_q;

    logic signed [WIDTH:0] acc;
    logic signed [WIDTH:0] mreg;
    logic [WIDTH-1:0]      qreg;
    logic                  qm1;
    logic                  neg_q;
    logic                  neg_r;

    logic signed [WIDTH:0] acc_nx;
    logic [WIDTH-1:0]      q_nx;
    logic                  qm1_nx;

    logic                  accept;
    logic                  dz;
    logic [WIDTH-1:0]      rem_fix;
    logic [2*WIDTH-1:0]    fix_res;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        return v[WIDTH-1] ? (~u + 1'b1) : u;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign accept = (state == S_IDLE) && bus.start;
    assign dz     = accept && (bus.op == OP_DIV) && (bus.opb == '0);

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .op     (op_q),
        .acc    (acc),
        .q      (qreg),
        .qm1    (qm1),
        .m      (mreg),
        .acc_nx (acc_nx),
        .q_nx   (q_nx),
        .qm1_nx (qm1_nx)
    );

    // Final correction: restore a negative remainder, then apply result signs.
    always_comb begin
        rem_fix = acc[WIDTH-1:0] + (acc[WIDTH] ? mreg[WIDTH-1:0] : '0);
        fix_res = {acc[WIDTH-1:0], qreg};
        if (op_q == OP_DIV) begin
            fix_res = {cond_neg(rem_fix, neg_r), cond_neg(qreg, neg_q)};
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_q       <= OP_MUL;
            div_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.op;
                        cnt  <= '0;
                        if (dz) begin
                            div_zero_q <= 1'b1;
                            result_q   <= {bus.opa, {WIDTH{1'b1}}};
                            state      <= S_DONE;
                        end else begin
                            div_zero_q <= 1'b0;
                            state      <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= fix_res;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath registers carry no reset; every accepted start reloads them.
    always_ff @(posedge clock) begin
        if (accept) begin
            acc <= '0;
            qm1 <= 1'b0;
            if (bus.op == OP_DIV) begin
                qreg  <= mag(bus.opa);
                mreg  <= {1'b0, mag(bus.opb)};
                neg_q <= bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1];
                neg_r <= bus.opa[WIDTH-1];
            end else begin
                qreg  <= bus.opb;
                mreg  <= {bus.opa[WIDTH-1], bus.opa};
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end
        end else if (state == S_RUN) begin
            acc  <= acc_nx;
            qreg <= q_nx;
            qm1  <= qm1_nx;
        end
    end

    assign bus.result   = result_q;
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, hand-written corner sequences
// and randomized operations checked against a plain-arithmetic reference.
module tb_mul_div_unit;

    logic clock = 1'b0;
    logic clear_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        bit          dz;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: {div_zero, result} from signed integer arithmetic.
    function automatic logic [64:0] model(input bit o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!o) return {1'b0, 64'(sa * sb)};
        if (sb == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input bit o, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output bit dz, output int lat);
        lat = -1;
        res = '0;
        dz  = 1'b0;
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = o;
        bus.opa   = a;
        bus.opb   = b;
        @(negedge clock);
        bus.start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (bus.done) begin
                lat = c;
                res = bus.result;
                dz  = bus.div_zero;
                break;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res;
        logic [64:0] exp;
        bit          dz;
        int          lat;
        int          dcnt;
        logic        busy_mid;

        vecs[0]  = '{1'b0, 32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 34};
        vecs[1]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 34};
        vecs[2]  = '{1'b0, 32'h7FFF_FFFF, 32'd2,         64'h0000_0000_FFFF_FFFE, 1'b0, 34};
        vecs[3]  = '{1'b1, 32'hFFFF_FFEF, 32'd5,         64'hFFFF_FFFE_FFFF_FFFD, 1'b0, 34};
        vecs[4]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 34};
        vecs[5]  = '{1'b1, 32'h1234_5678, 32'd0,         64'h1234_5678_FFFF_FFFF, 1'b1, 1};
        vecs[6]  = '{1'b0, 32'd2,         32'd3,         64'h0000_0000_0000_0006, 1'b0, 34};
        vecs[7]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 34};
        vecs[8]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h0000_0000_0000_0001, 1'b0, 34};
        vecs[9]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 34};
        vecs[10] = '{1'b1, 32'd5,         32'd7,         64'h0000_0005_0000_0000, 1'b0, 34};

        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.opa   = '0;
        bus.opb   = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_div_zero", 64'(bus.div_zero), 64'd0);
        clear_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, dz, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_div_zero", i), 64'(dz), 64'(vecs[i].dz));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            @(negedge clock);
            check($sformatf("vec%0d_idle_after", i), 64'({bus.busy, bus.done}), 64'd0);
        end

        // Start while busy is ignored: 100*3 with a divide request at cycle 10.
        @(negedge clock);
        bus.start = 1'b1; bus.op = 1'b0; bus.opa = 32'd100; bus.opb = 32'd3;
        @(negedge clock);
        bus.start = 1'b0;
        dcnt = 0; lat = -1; res = '0; busy_mid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) begin
                bus.start = 1'b1; bus.op = 1'b1; bus.opa = 32'd9; bus.opb = 32'd9;
            end else begin
                bus.start = 1'b0;
            end
            if (c == 5) busy_mid = bus.busy;
            if (bus.done) begin
                dcnt++;
                if (lat < 0) begin
                    lat = c;
                    res = bus.result;
                end
            end
            @(negedge clock);
        end
        check("busy_start_result", res, 64'd300);
        check("busy_start_done_count", 64'(dcnt), 64'd1);
        check("busy_start_latency", 64'(lat), 64'd34);
        check("busy_mid_run", 64'(busy_mid), 64'd1);

        // Start raised during the DONE cycle must not launch an operation.
        run_op(1'b0, 32'd6, 32'd7, res, dz, lat);
        check("done_start_first", res, 64'd42);
        bus.start = 1'b1; bus.op = 1'b0; bus.opa = 32'd5; bus.opb = 32'd5;
        @(negedge clock);
        bus.start = 1'b0;
        check("done_start_busy", 64'(bus.busy), 64'd0);
        @(negedge clock);
        check("done_start_still_idle", 64'(bus.busy), 64'd0);
        check("done_start_result_held", bus.result, 64'd42);

        // Asynchronous reset in the middle of a divide.
        @(negedge clock);
        bus.start = 1'b1; bus.op = 1'b1; bus.opa = 32'd1000; bus.opb = 32'd7;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (14) @(negedge clock);
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        #2 clear_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(bus.busy), 64'd0);
        check("async_rst_done", 64'(bus.done), 64'd0);
        check("async_rst_result", bus.result, 64'd0);
        check("async_rst_div_zero", 64'(bus.div_zero), 64'd0);
        @(negedge clock);
        clear_n = 1'b1;
        run_op(1'b1, 32'hFFFF_FFF4, 32'd4, res, dz, lat);
        check("post_rst_result", res, 64'h0000_0000_FFFF_FFFD);
        check("post_rst_latency", 64'(lat), 64'd34);

        for (int i = 0; i < 40; i++) begin
            bit          o;
            logic [31:0] a, b;
            int          mode;
            o    = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 4);
            a    = $urandom;
            b    = $urandom;
            case (mode)
                1: begin
                    a = 32'($signed($urandom_range(0, 40)) - 20);
                    b = 32'($signed($urandom_range(0, 40)) - 20);
                end
                2: b = '0;
                3: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'h8000_0000;
                        1: a = 32'hFFFF_FFFF;
                        2: a = 32'h7FFF_FFFF;
                        default: a = 32'd1;
                    endcase
                    case ($urandom_range(0, 3))
                        0: b = 32'h8000_0000;
                        1: b = 32'hFFFF_FFFF;
                        2: b = 32'h7FFF_FFFF;
                        default: b = 32'd1;
                    endcase
                end
                4: b = 32'($signed($urandom_range(1, 64)) - 32);
                default: ;
            endcase
            exp = model(o, a, b);
            run_op(o, a, b, res, dz, lat);
            check($sformatf("rand%0d_result op=%0d a=%h b=%h", i, o, a, b), res, exp[63:0]);
            check($sformatf("rand%0d_div_zero", i), 64'(dz), 64'(exp[64]));
            check($sformatf("rand%0d_latency", i), 64'(lat), exp[64] ? 64'd1 : 64'd34);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
